// File: rtl/wb_vmon_pkg.sv
// rtl/wb_vmon_pkg.sv - shared register map, status layout and FSM states for vmon mailbox responders
package wb_vmon_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STATUS_NOT_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT      = 1;
    localparam int STATUS_COUNT_LSB     = 2;

    localparam int CTRL_FLUSH_BIT = 0;

    typedef enum logic [1:0] {
        VMON_IDLE = 2'd0,
        VMON_WAIT = 2'd1,
        VMON_RESP = 2'd2
    } vmon_state_e;

endpackage

// File: rtl/wb_vmon_fifo.sv
// rtl/wb_vmon_fifo.sv - synchronous word FIFO with push/pop/flush and occupancy count
module wb_vmon_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Flush wins over any same-cycle push or pop.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_vmon_responder.sv
// rtl/wb_vmon_responder.sv - Wishbone classic slave draining the host-to-target vmon mailbox FIFO
module wb_vmon_responder
    import wb_vmon_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = 32'h6000_1010,
    parameter int                       FIFO_DEPTH    = 16,
    parameter int                       TIMEOUT       = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0]     ADR,
    input  logic [WB_DATA_WIDTH-1:0]     DAT_W,
    output logic [WB_DATA_WIDTH-1:0]     DAT_R,
    input  logic                         CYC,
    input  logic                         STB,
    input  logic                         WE,
    input  logic [WB_DATA_WIDTH/8-1:0]   SEL,
    output logic                         ACK,
    output logic                         ERR,
    input  logic [WB_DATA_WIDTH-1:0]     h2t_data,
    input  logic                         h2t_valid,
    output logic                         h2t_ready,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    vmon_state_e              state_q, state_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;

    logic                     hit;
    logic [1:0]               reg_off;
    logic                     fifo_pop;
    logic                     fifo_flush;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [WB_DATA_WIDTH-1:0] fifo_rdata;
    logic [CW-1:0]            fifo_count;
    logic [WB_DATA_WIDTH-1:0] status_w;
    logic                     unused_bits;

    assign hit     = CYC & STB & (ADR[WB_ADDR_WIDTH-1:4] == ADDRESS[WB_ADDR_WIDTH-1:4]);
    assign reg_off = ADR[3:2];

    assign unused_bits = ^{SEL, ADR[1:0], DAT_W[WB_DATA_WIDTH-1:1]};

    // Ready follows the registered full flag, so a same-cycle pop never frees a slot early.
    assign h2t_ready = ~fifo_full & ~fifo_flush;

    always_comb begin
        status_w                                 = '0;
        status_w[STATUS_NOT_EMPTY_BIT]           = ~fifo_empty;
        status_w[STATUS_FULL_BIT]                = fifo_full;
        status_w[STATUS_COUNT_LSB +: CW]         = fifo_count;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_r_d    = dat_r_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            VMON_IDLE: begin
                if (hit) begin
                    state_d = VMON_RESP;
                    case (reg_off)
                        REG_DATA: begin
                            if (WE) begin
                                err_d   = 1'b1;
                                dat_r_d = '0;
                            end else if (!fifo_empty) begin
                                fifo_pop = 1'b1;
                                dat_r_d  = fifo_rdata;
                                ack_d    = 1'b1;
                            end else if (TIMEOUT > 0) begin
                                state_d = VMON_WAIT;
                                timer_d = '0;
                            end else begin
                                err_d   = 1'b1;
                                dat_r_d = '0;
                            end
                        end
                        REG_STATUS: begin
                            ack_d = 1'b1;
                            if (!WE) begin
                                dat_r_d = status_w;
                            end
                        end
                        REG_CTRL: begin
                            ack_d = 1'b1;
                            if (WE) begin
                                fifo_flush = DAT_W[CTRL_FLUSH_BIT];
                            end else begin
                                dat_r_d = '0;
                            end
                        end
                        default: begin
                            ack_d = 1'b1;
                            if (!WE) begin
                                dat_r_d = '0;
                            end
                        end
                    endcase
                end
            end

            // Blocking DATA read: a master abort takes priority over late data.
            VMON_WAIT: begin
                if (!CYC) begin
                    state_d = VMON_IDLE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    dat_r_d  = fifo_rdata;
                    ack_d    = 1'b1;
                    state_d  = VMON_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    dat_r_d = '0;
                    state_d = VMON_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            VMON_RESP: begin
                state_d = VMON_IDLE;
            end

            default: begin
                state_d = VMON_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= VMON_IDLE;
            timer_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
        end
    end

    wb_vmon_fifo #(
        .WIDTH (WB_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (h2t_valid & h2t_ready),
        .wdata_i (h2t_data),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign DAT_R = dat_r_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign count = fifo_count;

endmodule

// File: tb/tb_wb_vmon_responder.sv
// tb/tb_wb_vmon_responder.sv - self-checking bench for wb_vmon_responder at TIMEOUT 1024, 16 and 0
module tb_wb_vmon_responder;

    localparam logic [31:0] BASE = 32'h6000_1010;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr       [3];
    logic [31:0] dat_w     [3];
    logic [31:0] dat_r     [3];
    logic        cyc       [3];
    logic        stb       [3];
    logic        we        [3];
    logic [3:0]  sel       [3];
    logic        ack       [3];
    logic        err       [3];
    logic [31:0] h2t_data  [3];
    logic        h2t_valid [3];
    logic        h2t_ready [3];
    logic [4:0]  count     [3];

    int          tests;
    int          fails;
    logic [31:0] mq [$];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        wb_vmon_responder #(
            .TIMEOUT (g == 0 ? 1024 : (g == 1 ? 16 : 0))
        ) u_dut (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .ADR       (adr[g]),
            .DAT_W     (dat_w[g]),
            .DAT_R     (dat_r[g]),
            .CYC       (cyc[g]),
            .STB       (stb[g]),
            .WE        (we[g]),
            .SEL       (sel[g]),
            .ACK       (ack[g]),
            .ERR       (err[g]),
            .h2t_data  (h2t_data[g]),
            .h2t_valid (h2t_valid[g]),
            .h2t_ready (h2t_ready[g]),
            .count     (count[g])
        );
    end

    always #5 clk = ~clk;

    initial begin
        #400_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Status word as software sees it: {count, full, not_empty}.
    function automatic logic [31:0] status_exp(input int n);
        logic [31:0] s;
        s = 32'(n) << 2;
        if (n == 16) s[1] = 1'b1;
        if (n != 0)  s[0] = 1'b1;
        return s;
    endfunction

    task automatic bus_xfer(input int i, input logic [31:0] a, input logic w, input logic [31:0] wd,
                            input int push_at, input logic [31:0] pw, input int lim,
                            output int lat, output logic g_ack, output logic g_err,
                            output logic [31:0] rd);
        adr[i] = a; we[i] = w; dat_w[i] = wd; cyc[i] = 1'b1; stb[i] = 1'b1;
        lat = 0; g_ack = 1'b0; g_err = 1'b0; rd = '0;
        for (int n = 1; n <= lim && lat == 0; n++) begin
            if (push_at == n) begin
                h2t_valid[i] = 1'b1;
                h2t_data[i]  = pw;
            end
            tick();
            if (push_at == n) h2t_valid[i] = 1'b0;
            if (ack[i] || err[i]) begin
                lat = n; g_ack = ack[i]; g_err = err[i]; rd = dat_r[i];
            end
        end
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic do_xfer(input int i, input logic [3:0] off, input logic w, input logic [31:0] wd,
                           input int push_at, input logic [31:0] pw, input int exp_lat,
                           input logic exp_ack, input logic exp_err, input logic chk_rd,
                           input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic        ga;
        logic        ge;
        logic [31:0] rd;
        bus_xfer(i, BASE + 32'(off), w, wd, push_at, pw, (exp_lat == 0) ? 40 : exp_lat + 20,
                 lat, ga, ge, rd);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ack"}, 32'(ga), 32'(exp_ack));
        check({tag, "_err"}, 32'(ge), 32'(exp_err));
        if (chk_rd) check({tag, "_dat"}, rd, exp_rd);
        tick();
        check({tag, "_pulse"}, 32'({ack[i], err[i]}), 32'd0);
    endtask

    task automatic push_word(input int i, input logic [31:0] w, input string tag);
        h2t_valid[i] = 1'b1;
        h2t_data[i]  = w;
        #1;
        check({tag, "_rdy"}, 32'(h2t_ready[i]), 32'(mq.size() < 16));
        tick();
        h2t_valid[i] = 1'b0;
        if (mq.size() < 16) mq.push_back(w);
        check({tag, "_cnt"}, 32'(count[i]), 32'(mq.size()));
    endtask

    task automatic read_expect(input int i, input string tag);
        logic [31:0] e;
        e = mq.pop_front();
        do_xfer(i, 4'h0, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, e, tag);
    endtask

    initial begin
        int          np;
        int          nr;
        int          pa;
        int          lat;
        logic        ga;
        logic        ge;
        logic        acc;
        logic [31:0] rd;
        logic [31:0] w;
        logic [31:0] e;

        tests = 0;
        fails = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; dat_w[i] = '0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = 4'hF; h2t_data[i] = '0; h2t_valid[i] = 1'b0;
        end
        #1;
        check("rst_ack", 32'(ack[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_datr", dat_r[0], 32'd0);
        check("rst_count", 32'(count[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(h2t_ready[0]), 32'd1);

        push_word(0, 32'hDEAD_BEEF, "basic_push0");
        push_word(0, 32'h1234_5678, "basic_push1");
        read_expect(0, "basic_rd0");
        read_expect(0, "basic_rd1");
        do_xfer(0, 4'h4, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, 32'd0, "basic_status");

        do_xfer(0, 4'h0, 1'b1, 32'h55, 0, 32'd0, 1, 1'b0, 1'b1, 1'b1, 32'd0, "data_write");
        do_xfer(0, 4'h8, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, 32'd0, "ctrl_read");
        do_xfer(0, 4'hC, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, 32'd0, "reg3_read");
        do_xfer(0, 4'h4, 1'b1, 32'hFF, 0, 32'd0, 1, 1'b1, 1'b0, 1'b0, 32'd0, "status_write");
        bus_xfer(0, BASE + 32'h20, 1'b0, 32'd0, 0, 32'd0, 20, lat, ga, ge, rd);
        check("miss_resp", 32'({ga, ge}), 32'd0);

        repeat (6) begin
            np = $urandom_range(1, 8);
            for (int k = 0; k < np; k++) begin
                push_word(0, $urandom, "rnd_push");
                repeat ($urandom_range(0, 2)) tick();
            end
            nr = $urandom_range(1, mq.size());
            for (int k = 0; k < nr; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    w   = $urandom;
                    acc = (mq.size() < 16);
                    e   = mq.pop_front();
                    do_xfer(0, 4'h0, 1'b0, 32'd0, 1, w, 1, 1'b1, 1'b0, 1'b1, e, "rnd_pushpop");
                    if (acc) mq.push_back(w);
                    check("rnd_pushpop_cnt", 32'(count[0]), 32'(mq.size()));
                end else begin
                    read_expect(0, "rnd_rd");
                end
            end
            do_xfer(0, 4'h4, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, status_exp(mq.size()),
                    "rnd_status");
        end
        while (mq.size() > 0) read_expect(0, "rnd_drain");
        do_xfer(0, 4'h4, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, 32'd0, "drain_status");

        do_xfer(0, 4'h0, 1'b0, 32'd0, 50, 32'hA5A5_0001, 51, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001,
                "wait50");
        pa = $urandom_range(2, 200);
        w  = $urandom;
        do_xfer(0, 4'h0, 1'b0, 32'd0, pa, w, pa + 1, 1'b1, 1'b0, 1'b1, w, "wait_rnd");

        do_xfer(1, 4'h0, 1'b0, 32'd0, 0, 32'd0, 17, 1'b0, 1'b1, 1'b1, 32'd0, "timeout16");
        check("timeout16_cnt", 32'(count[1]), 32'd0);
        do_xfer(2, 4'h0, 1'b0, 32'd0, 0, 32'd0, 1, 1'b0, 1'b1, 1'b1, 32'd0, "nonblock");

        for (int k = 0; k < 16; k++) push_word(0, $urandom, "fill");
        check("full_ready", 32'(h2t_ready[0]), 32'd0);
        do_xfer(0, 4'h4, 1'b0, 32'd0, 0, 32'd0, 1, 1'b1, 1'b0, 1'b1, 32'h43, "full_status");
        w = $urandom;
        h2t_valid[0] = 1'b1;
        h2t_data[0]  = w;
        e = mq.pop_front();
        bus_xfer(0, BASE, 1'b0, 32'd0, 0, 32'd0, 5, lat, ga, ge, rd);
        check("fullpop_lat", 32'(lat), 32'd1);
        check("fullpop_dat", rd, e);
        check("fullpop_cnt", 32'(count[0]), 32'd15);
        check("fullpop_rdy", 32'(h2t_ready[0]), 32'd1);
        tick();
        h2t_valid[0] = 1'b0;
        mq.push_back(w);
        check("refill_cnt", 32'(count[0]), 32'd16);
        check("refill_rdy", 32'(h2t_ready[0]), 32'd0);
        while (mq.size() > 0) read_expect(0, "wrap_rd");

        for (int k = 0; k < 5; k++) push_word(2, $urandom, "fl_push");
        h2t_valid[2] = 1'b1; h2t_data[2] = $urandom;
        adr[2] = BASE + 32'h8; we[2] = 1'b1; dat_w[2] = 32'd1; cyc[2] = 1'b1; stb[2] = 1'b1;
        #1;
        check("flush_rdy", 32'(h2t_ready[2]), 32'd0);
        tick();
        check("flush_ack", 32'(ack[2]), 32'd1);
        check("flush_cnt", 32'(count[2]), 32'd0);
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0; h2t_valid[2] = 1'b0;
        mq.delete();
        tick();
        check("flush_cnt2", 32'(count[2]), 32'd0);
        do_xfer(2, 4'h0, 1'b0, 32'd0, 0, 32'd0, 1, 1'b0, 1'b1, 1'b1, 32'd0, "flush_rd");

        for (int k = 0; k < 3; k++) push_word(2, $urandom, "pre_rst");
        adr[0] = BASE; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        repeat (6) tick();
        check("wait_noresp", 32'({ack[0], err[0]}), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_resp", 32'({ack[0], err[0]}), 32'd0);
        check("rstw_cnt2", 32'(count[2]), 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        mq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rstw_ready", 32'(h2t_ready[0]), 32'd1);
        push_word(0, 32'hC0DE_0042, "post_rst");
        read_expect(0, "post_rst_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
